// File: rtl/gf_ds_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gf_ds_mult : digit-serial GF(2^M) polynomial-basis multiplier, MSB-first    |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module gf_ds_mult #(
  parameter int unsigned   M    = 16,
  parameter int unsigned   D    = 4,
  parameter logic [M-1:0]  POLY = 16'h002B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c,
  output logic         busy
);

  localparam int unsigned C_N    = (M + D - 1) / D;
  localparam int unsigned C_BW   = C_N * D;
  localparam int unsigned C_CNTW = (C_N > 1) ? $clog2(C_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [M-1:0]        r_acc;
  logic [M-1:0]        r_a;
  logic [C_BW-1:0]     r_b;
  logic [C_CNTW-1:0]   r_cnt;
  logic [D-1:0]        w_digit;
  logic [M-1:0]        w_acc_next;
  logic                w_accept;
  logic                w_last;

  // b_reg shifts left each RUN cycle, so the digit being consumed is always on top.
  assign w_digit  = r_b[C_BW-1 -: D];
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == '0);

  // Horner step: acc <- acc * x^D + digit * a, reduced one bit at a time.
  always_comb begin
    logic [M-1:0] t;
    logic         msb;
    t = r_acc;
    for (int j = D - 1; j >= 0; j--) begin
      msb = t[M-1];
      t   = t << 1;
      if (msb) t = t ^ POLY;
      if (w_digit[j]) t = t ^ r_a;
    end
    w_acc_next = t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    c            = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        c         = r_acc;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_a   <= a;
      r_b   <= C_BW'(b);
      r_cnt <= C_CNTW'(C_N - 1);
    end else if (r_state == RUN) begin
      r_acc <= w_acc_next;
      r_b   <= r_b << D;
      if (!w_last) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf_ds_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_gf_ds_mult : directed + random checks of gf_ds_mult (D=4 and D=3)        |
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module tb_gf_ds_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, busy4;
  logic [15:0] c4;

  logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic [15:0] a3 = '0, b3 = '0;
  logic        in_ready3, out_valid3, busy3;
  logic [15:0] c3;

  gf_ds_mult #(.M(16), .D(4), .POLY(16'h002B)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .c(c4), .busy(busy4)
  );

  gf_ds_mult #(.M(16), .D(3), .POLY(16'h002B)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
    .c(c3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full carry-less product, then long division by x^16+x^5+x^3+x+1.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (y[i]) p = p ^ (32'(x) << i);
    for (int i = 30; i >= 16; i--)
      if (p[i]) p = p ^ (32'h0001_002B << (i - 16));
    return p[15:0];
  endfunction

  function automatic logic ov(input bit s3);  return s3 ? out_valid3 : out_valid4; endfunction
  function automatic logic ir(input bit s3);  return s3 ? in_ready3  : in_ready4;  endfunction
  function automatic logic bz(input bit s3);  return s3 ? busy3      : busy4;      endfunction
  function automatic logic [15:0] cv(input bit s3); return s3 ? c3 : c4; endfunction

  // One full transaction: accept, count latency, check result, release.
  task automatic txn(input bit s3, input logic [15:0] ta, input logic [15:0] tb2,
                     input logic [15:0] exp, input string tag);
    int lat;
    bit bad;
    chk({tag, "/in_ready_idle"}, 32'(ir(s3)), 32'd1);
    if (s3) begin a3 = ta; b3 = tb2; in_valid3 = 1'b1; end
    else    begin a4 = ta; b4 = tb2; in_valid4 = 1'b1; end
    @(posedge clk); #1;
    in_valid3 = 1'b0; in_valid4 = 1'b0;
    lat = 0; bad = 1'b0;
    while (!ov(s3) && lat < 40) begin
      if (ir(s3) || !bz(s3)) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), s3 ? 32'd6 : 32'd4);
    chk({tag, "/ready_low_in_run"}, 32'(bad), 32'd0);
    chk({tag, "/c"}, 32'(cv(s3)), 32'(exp));
    if (s3) out_ready3 = 1'b1; else out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0; out_ready4 = 1'b0;
    chk({tag, "/valid_dropped"}, 32'(ov(s3)), 32'd0);
    chk({tag, "/ready_back"}, 32'(ir(s3)), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int lat;

    // Reset values
    #12;
    chk("rst/in_ready", 32'(in_ready4), 32'd1);
    chk("rst/out_valid", 32'(out_valid4), 32'd0);
    chk("rst/busy", 32'(busy4), 32'd0);
    chk("rst/c", 32'(c4), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products on the default configuration
    txn(1'b0, 16'h0001, 16'h0002, 16'h0002, "d4_basic");
    txn(1'b0, 16'h8000, 16'h0002, 16'h002B, "d4_reduce1");
    txn(1'b0, 16'h8000, 16'h8000, 16'hC10E, "d4_reduce2");
    txn(1'b0, 16'hBEEF, 16'h0001, 16'hBEEF, "d4_ident");
    txn(1'b0, 16'h0001, 16'hBEEF, 16'hBEEF, "d4_ident_sw");
    txn(1'b0, 16'h1234, 16'h0000, 16'h0000, "d4_zero");
    txn(1'b0, 16'h0000, 16'h1234, 16'h0000, "d4_zero_sw");
    txn(1'b0, 16'hFFFF, 16'hFFFF, ref_mul(16'hFFFF, 16'hFFFF), "d4_ones");

    // Backpressure and ignored in_valid while busy
    a4 = 16'h8000; b4 = 16'h0002; in_valid4 = 1'b1;
    @(posedge clk); #1;
    a4 = 16'hFFFF; b4 = 16'hFFFF;
    lat = 0;
    while (!out_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp/latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp/c_stable", 32'(c4), 32'h002B);
      chk("bp/valid_stable", 32'(out_valid4), 32'd1);
      chk("bp/in_ready_low", 32'(in_ready4), 32'd0);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("bp/idle_ready", 32'(in_ready4), 32'd1);
    chk("bp/idle_valid", 32'(out_valid4), 32'd0);
    txn(1'b0, 16'h8000, 16'h8000, 16'hC10E, "bp_after");

    // Asynchronous reset two cycles into RUN
    a4 = 16'h1234; b4 = 16'h5678; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mrst/busy_before", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst/in_ready", 32'(in_ready4), 32'd1);
    chk("mrst/out_valid", 32'(out_valid4), 32'd0);
    chk("mrst/busy", 32'(busy4), 32'd0);
    chk("mrst/c", 32'(c4), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst/ready_after", 32'(in_ready4), 32'd1);
    chk("mrst/no_stray_valid", 32'(out_valid4), 32'd0);
    txn(1'b0, 16'h8000, 16'h0002, 16'h002B, "mrst_next");

    // Random on the default configuration
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      txn(1'b0, ra, rb, ref_mul(ra, rb), "d4_rand");
    end

    // Padded top digit: D=3, N=6
    txn(1'b1, 16'h8000, 16'h0002, 16'h002B, "d3_reduce1");
    txn(1'b1, 16'h8000, 16'h8000, 16'hC10E, "d3_reduce2");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      txn(1'b1, ra, rb, ref_mul(ra, rb), "d3_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf_ds_mult.md
Name: gf_ds_mult

Overview:
Parametrised digit-serial GF(2^M) multiplier. It is the sequential successor to the single-bit AND/AND/XOR systolic cell.
- Computes C = A·B mod P(x) in polynomial basis, consuming D bits of B per clock, MSB-first.
- One multiplication takes ceil(M/D) cycles.
- Valid/ready handshake on both sides, so it drops into the multiplier datapath between operand staging and result collection.

Parameters:
- M, 16, field degree; operand and result width.
- D, 4, digit size in bits (1 <= D <= M). M need not be a multiple of D.
- POLY, 16'h002B, low M coefficients of the irreducible P(x); x^M is implicit. Default is x^16+x^5+x^3+x+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b presented
- in_ready  output  1  block can accept operands
- a  input  M  multiplicand (bit i = coeff of x^i)
- b  input  M  multiplier (bit i = coeff of x^i)
- out_valid  output  1  result c valid
- out_ready  input  1  downstream accepts c
- c  output  M  product a·b mod P
- busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low: assertion immediately clears all state.
- Reset values:
  - state = IDLE; acc, a_reg, b_reg and the digit counter all 0.
  - in_ready = 1, out_valid = 0, busy = 0, c = 0.
- Derived constants:
  - N = ceil(M/D).
  - b_reg is N·D bits wide. b is zero-extended at the MSB end, so the top digit is padded; this does not change the product.
- FSM with states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch a_reg <= a and b_reg <= zero-extended b, clear acc to 0, set cnt <= N-1, go to RUN. Otherwise stay.
  - RUN: in_ready = 0. Each cycle processes digit g = b_reg[cnt·D +: D] and updates acc. When cnt == 0, go to DONE; otherwise cnt <= cnt-1.
  - DONE: out_valid = 1 and c = acc. On out_ready, go to IDLE. Otherwise hold; c stays stable and out_valid stays high.
- Per-cycle RUN update is a D-step unrolled chain, for j = D-1 down to 0:
  - t <= (t << 1) with the x^M term folded back: if t[M-1] was 1, XOR in POLY.
  - then t <= t XOR (g[j] ? a_reg : 0).
  - The chain starts from t = acc and ends by writing acc <= t.
  - The data path is purely combinational AND/XOR logic. There are no multiplier primitives.
- Latency: operands accepted at clock edge k → out_valid rises after edge k+N. For the defaults (M=16, D=4), N = 4.
- Throughput: one result per N+2 cycles when out_ready is held high. in_ready is asserted only in IDLE, so there is one bubble cycle.
- in_valid is ignored outside IDLE. Operands presented while busy are not captured, and the source must hold them.
- out_ready is ignored outside DONE.
- rst_n asserted mid-RUN or in DONE: the operation is discarded and no out_valid pulse occurs. After release, the block is in IDLE with in_ready = 1 on the first clock.
- Special operands:
  - a = 0 or b = 0 → c = 0.
  - b = 1 → c = a (a < 2^M is already reduced).
- All widths are exact: acc and c are M bits, and no intermediate exceeds M+1 bits before reduction.

Test Plan:
- Defaults: a=16'h0001, b=16'h0002 → c=16'h0002. out_valid is high exactly 4 cycles after the accept edge; in_ready is low throughout.
- Reduction: a=16'h8000, b=16'h0002 → c=16'h002B. Also a=16'h8000, b=16'h8000 → c=16'hC10E.
- Identity and zero: a=16'hBEEF, b=16'h0001 → 16'hBEEF; a=16'h1234, b=0 → 0. Swapping a and b gives the same c.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → c and out_valid stay stable and in_ready stays 0.
  - in_valid asserted with a new operand during RUN/DONE is not captured.
  - Releasing out_ready returns the block to IDLE.
- Padded digits: M=16, D=3 (N=6), 1000 random (a, b) pairs → each c matches a bit-serial reference model; latency is 6 cycles.
- Reset mid-operation: drop rst_n 2 cycles into RUN → outputs go to reset values asynchronously. After release, the next transaction a=16'h8000, b=16'h0002 produces 16'h002B with no stray out_valid in between.
